rr_arbiter_4: RTL and testbench

- Round-robin arbiter sharing one downstream resource between 4 requesters.
- Each requester holds its request for as long as it needs the resource.
- Outputs are a one-hot grant plus a 2-bit encoded index (same encoding as the 4-to-2 encoder: idx = {g2|g3, g1|g3}). The index drives the resource's select/mux.
- Sits between the request sources and the shared datapath. It is the sequencer that decides who owns the encoder-selected path each cycle.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_priority_encoder.sv | 48 ++++
 rtl/rr_arbiter_4.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and index encode for the 4-way round-robin arbiter
//
// Purpose : common definitions imported by rr_priority_encoder and rr_arbiter_4.
// Contents: N_REQ, IDX_W, arb_state_t {IDLE, BUSY}, onehot_to_idx().

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // 4-to-2 encode of a one-hot vector: idx = {g2|g3, g1|g3}; all-zero maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    return {oh[2] | oh[3], oh[1] | oh[3]};
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - rotating-priority pick of one request starting at ptr
//
// Purpose : combinational; picks the first set bit of req scanning ptr, ptr+1, ... mod 4.
// Ports   : req      in  [3:0] candidate requests
//           ptr      in  [1:0] highest-priority position for this scan
//           pick     out [3:0] one-hot winner, zero when req is zero
//           pick_idx out [1:0] encoded winner, zero when req is zero
//           any      out       at least one request present

module rr_priority_encoder
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rot_pick;

  always_comb begin
    rot      = '0;
    rot_pick = '0;
    pick     = '0;

    // Rotate so that position ptr lands on bit 0; the 2-bit cast wraps mod 4.
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i + int'(ptr))];
    end

    // Fixed priority: lowest rotated bit wins.
    if (rot[0])      rot_pick = 4'b0001;
    else if (rot[1]) rot_pick = 4'b0010;
    else if (rot[2]) rot_pick = 4'b0100;
    else if (rot[3]) rot_pick = 4'b1000;

    // Rotate the winner back into requester numbering.
    for (int i = 0; i < N_REQ; i++) begin
      pick[IDX_W'(i + int'(ptr))] = rot_pick[i];
    end
  end

  assign pick_idx = onehot_to_idx(pick);
  assign any      = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-requester round-robin arbiter with registered one-hot grant and index
//
// Purpose : owns the shared datapath select; an owner keeps the grant while it holds req and
//           the grant passes straight to the next requester in rotation when it lets go.
// Option  : ARB_TIMEOUT_EN - forcibly revokes an owner after MAX_HOLD cycles while others wait.
// Ports   : clk         in        rising-edge clock
//           rst_n       in        asynchronous active-low reset
//           req         in  [3:0] request vector, held for as long as the resource is needed
//           grant       out [3:0] one-hot registered grant, zero when idle
//           grant_idx   out [1:0] encoded owner, zero when idle
//           grant_valid out       OR of grant
//           timeout     out       one-cycle pulse on forced revoke; 0 without ARB_TIMEOUT_EN

module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;

  logic [IDX_W-1:0] scan_ptr;
  logic [N_REQ-1:0] scan_req;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             revoke;

  assign owner_req = req[grant_idx];

  // While busy the next owner is searched from owner+1, which is exactly the ptr value that
  // release/revoke commits, so the hand-off happens in the same edge. The current owner is
  // masked out so a revoke can never re-select it; on release its bit is already low.
  assign scan_ptr = (state == BUSY) ? grant_idx + IDX_W'(1) : ptr;
  assign scan_req = req & ~grant;

  rr_priority_encoder u_pick (
    .req      (scan_req),
    .ptr      (scan_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  // Only revoke when someone else is actually waiting; a lone owner keeps the resource.
  assign revoke = (state == BUSY) && owner_req && (hold_cnt == HOLD_LAST) && pick_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= revoke;
      // Any change of ownership (new grant, release, revoke) restarts the count from zero.
      if (state == IDLE || !owner_req || revoke) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant       <= pick;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req || revoke) begin
            ptr <= scan_ptr;
            if (pick_any) begin
              grant       <= pick;
              grant_idx   <= pick_idx;
              grant_valid <= 1'b1;
            end else begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - self-checking bench for rr_arbiter_4 (vector table, corner sequences, random vs model)

module tb_rr_arbiter_4;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = nobody), rotation start, cycles held so far.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
  } vec_t;

  vec_t tbl[15];

  function automatic int scan(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r);
`ifdef ARB_TIMEOUT_EN
    logic [3:0] others;
`endif
    m_to = 1'b0;
    if (m_owner < 0) begin
      m_owner = scan(r, m_ptr);
      m_hold  = 0;
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = scan(r, m_ptr);
      m_hold  = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      others          = r;
      others[m_owner] = 1'b0;
      if (m_hold >= MAXH - 1 && others != 4'b0000) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = scan(others, m_ptr);
        m_hold  = 0;
        m_to    = 1'b1;
      end else if (m_hold < MAXH - 1) begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    ei = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    chk({tag, ".grant"},     grant,               eg);
    chk({tag, ".grant_idx"}, {2'b00, grant_idx},  {2'b00, ei});
    chk({tag, ".valid"},     {3'b000, grant_valid}, {3'b000, (m_owner >= 0)});
    chk({tag, ".timeout"},   {3'b000, timeout},   {3'b000, m_to});
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk_model(tag);
  endtask

  // Async reset applied mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_grant"}, grant, 4'b0000);
    chk({tag, ".rst_misc"}, {1'b0, timeout, grant_valid, |grant_idx}, 4'b0000);
    model_reset();
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();

    for (int k = 0; k < 5; k++) tbl[k] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[6]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[9]  = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    tbl[10] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[11] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[13] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.grant", grant, 4'b0000);
    chk("reset.misc", {1'b0, timeout, grant_valid, |grant_idx}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      step(tbl[k].r, "tbl_model");
      chk("tbl.grant", grant, tbl[k].g);
      chk("tbl.idx", {2'b00, grant_idx}, {2'b00, tbl[k].i});
      chk("tbl.valid", {3'b000, grant_valid}, {3'b000, tbl[k].v});
    end

    // All request; each owner holds 3 cycles then drops for one cycle.
    do_reset("rot");
    step(4'b1111, "rot");
    for (int k = 0; k < 5; k++) begin
      chk("rot.order", {2'b00, grant_idx}, 4'(k % 4));
      step(4'b1111, "rot");
      step(4'b1111, "rot");
      step(4'b1111 & ~4'(1 << (k % 4)), "rot");
    end

    // Async reset while requester 3 owns the resource, then re-arbitrate.
    do_reset("ar");
    step(4'b1000, "ar");
    chk("ar.owner3", grant, 4'b1000);
    do_reset("ar_mid");
    step(4'b1000, "ar_after");
    chk("ar.regrant", grant, 4'b1000);

`ifdef ARB_TIMEOUT_EN
    do_reset("to");
    step(4'b0011, "to");
    for (int k = 0; k < MAXH - 1; k++) begin
      step(4'b0011, "to_hold");
      chk("to.held", grant, 4'b0001);
    end
    step(4'b0011, "to_rev");
    chk("to.moved", grant, 4'b0010);
    chk("to.pulse", {3'b000, timeout}, 4'b0001);
    step(4'b0011, "to_after");
    chk("to.pulse_end", {3'b000, timeout}, 4'b0000);

    do_reset("alone");
    for (int k = 0; k < 3 * MAXH; k++) begin
      step(4'b0001, "alone");
      chk("alone.no_timeout", {3'b000, timeout}, 4'b0000);
      chk("alone.kept", grant, 4'b0001);
    end
`endif

    // Random requests with persistence so owners hold for a while; rare mid-run resets.
    do_reset("rnd");
    r = 4'b0000;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_rst");
      end
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = 1'b0;
      step(r, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
